// File: rtl/ftdi_async_dev.sv
// rtl/ftdi_async_dev.sv - FT245-style async FIFO bus device responder with RX/TX byte FIFOs
// Optional feature macro: FTDI_ASYNC_DEV_LOOPBACK_EN (adds loopback_i, TX pops feed the RX FIFO)
module ftdi_async_dev #(
    parameter int DEPTH       = 16,
    parameter int ADDR_W      = 4,
    parameter int RXF_HOLDOFF = 3,
    parameter int TXE_HOLDOFF = 3
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       ftdi_rdn_i,
    input  logic       ftdi_wrn_i,
    input  logic [7:0] ftdi_data_in_i,
    output logic       ftdi_rxf_o,
    output logic       ftdi_txe_o,
    output logic [7:0] ftdi_data_out_o,
    output logic       ftdi_data_oe_o,
    input  logic       host_in_valid_i,
    input  logic [7:0] host_in_data_i,
    output logic       host_in_accept_o,
    output logic       host_out_valid_o,
    output logic [7:0] host_out_data_o,
    input  logic       host_out_accept_i,
`ifdef FTDI_ASYNC_DEV_LOOPBACK_EN
    input  logic       loopback_i,
`endif
    output logic       protocol_err_o
);
    typedef enum logic [1:0] {R_IDLE, R_READY, R_ACTIVE, R_HOLD} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_ACTIVE, W_HOLD} w_state_t;

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    logic [7:0]      rx_mem [DEPTH];
    logic [7:0]      tx_mem [DEPTH];
    logic [ADDR_W:0] rx_wp, rx_rp, tx_wp, tx_rp;
    logic            rx_empty, rx_full, tx_empty, tx_full;
    logic            rx_push, rx_pop, tx_push, tx_pop;
    logic [7:0]      rx_push_data;
    logic            lb, lb_move;

    logic            rd_s1, rd_s2, rd_q, wr_s1, wr_s2, wr_q;
    logic            rd_fall, rd_rise, wr_fall, wr_rise, both_low;

    r_state_t        r_state;
    w_state_t        w_state;
    logic [7:0]      r_cnt, w_cnt;

`ifdef FTDI_ASYNC_DEV_LOOPBACK_EN
    assign lb = loopback_i;
`else
    assign lb = 1'b0;
`endif

    assign rx_empty = (rx_wp == rx_rp);
    assign rx_full  = ((rx_wp - rx_rp) == FULL_CNT);
    assign tx_empty = (tx_wp == tx_rp);
    assign tx_full  = ((tx_wp - tx_rp) == FULL_CNT);

    assign rd_fall  = rd_q & ~rd_s2;
    assign rd_rise  = ~rd_q & rd_s2;
    assign wr_fall  = wr_q & ~wr_s2;
    assign wr_rise  = ~wr_q & wr_s2;
    assign both_low = ~rd_s2 & ~wr_s2;

    assign host_in_accept_o = ~rx_full & ~lb;
    assign host_out_valid_o = ~tx_empty & ~lb;
    assign host_out_data_o  = tx_mem[tx_rp[ADDR_W-1:0]];

    // In loopback the TX head moves straight into RX whenever RX has room.
    assign lb_move      = lb & ~tx_empty & ~rx_full;
    assign rx_push      = (host_in_valid_i & host_in_accept_o) | lb_move;
    assign rx_push_data = lb ? host_out_data_o : host_in_data_i;
    assign tx_pop       = (host_out_valid_o & host_out_accept_i) | lb_move;
    assign rx_pop       = (r_state == R_ACTIVE) & rd_rise & ~both_low;
    assign tx_push      = (w_state == W_IDLE) & wr_fall & ~ftdi_txe_o & ~both_low;

    always_ff @(posedge clk_i) begin
        if (rx_push) rx_mem[rx_wp[ADDR_W-1:0]] <= rx_push_data;
        if (tx_push) tx_mem[tx_wp[ADDR_W-1:0]] <= ftdi_data_in_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_wp <= '0;
            rx_rp <= '0;
            tx_wp <= '0;
            tx_rp <= '0;
        end else begin
            if (rx_push) rx_wp <= rx_wp + 1'b1;
            if (rx_pop)  rx_rp <= rx_rp + 1'b1;
            if (tx_push) tx_wp <= tx_wp + 1'b1;
            if (tx_pop)  tx_rp <= tx_rp + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_s1           <= 1'b1;
            rd_s2           <= 1'b1;
            rd_q            <= 1'b1;
            wr_s1           <= 1'b1;
            wr_s2           <= 1'b1;
            wr_q            <= 1'b1;
            r_state         <= R_IDLE;
            w_state         <= W_IDLE;
            r_cnt           <= '0;
            w_cnt           <= '0;
            ftdi_rxf_o      <= 1'b1;
            ftdi_txe_o      <= 1'b1;
            ftdi_data_out_o <= '0;
            ftdi_data_oe_o  <= 1'b0;
            protocol_err_o  <= 1'b0;
        end else begin
            rd_s1 <= ftdi_rdn_i;
            rd_s2 <= rd_s1;
            rd_q  <= rd_s2;
            wr_s1 <= ftdi_wrn_i;
            wr_s2 <= wr_s1;
            wr_q  <= wr_s2;

            if ((rd_fall && ftdi_rxf_o) || (wr_fall && ftdi_txe_o) || both_low)
                protocol_err_o <= 1'b1;

            if (both_low) begin
                r_state        <= R_IDLE;
                w_state        <= W_IDLE;
                ftdi_rxf_o     <= 1'b1;
                ftdi_txe_o     <= 1'b1;
                ftdi_data_oe_o <= 1'b0;
            end else begin
                case (r_state)
                    R_IDLE: if (!rx_empty) begin
                        ftdi_data_out_o <= rx_mem[rx_rp[ADDR_W-1:0]];
                        ftdi_rxf_o      <= 1'b0;
                        r_state         <= R_READY;
                    end
                    R_READY: if (rd_fall) begin
                        ftdi_data_oe_o <= 1'b1;
                        r_state        <= R_ACTIVE;
                    end
                    R_ACTIVE: if (rd_rise) begin
                        ftdi_rxf_o     <= 1'b1;
                        ftdi_data_oe_o <= 1'b0;
                        r_cnt          <= 8'(RXF_HOLDOFF);
                        r_state        <= R_HOLD;
                    end
                    R_HOLD: begin
                        // A zero holdoff still spends one cycle here.
                        if (r_cnt <= 8'd1) r_state <= R_IDLE;
                        else               r_cnt   <= r_cnt - 8'd1;
                    end
                    default: r_state <= R_IDLE;
                endcase

                case (w_state)
                    W_IDLE: begin
                        if (wr_fall && !ftdi_txe_o) begin
                            ftdi_txe_o <= 1'b1;
                            w_state    <= W_ACTIVE;
                        end else begin
                            ftdi_txe_o <= tx_full;
                        end
                    end
                    W_ACTIVE: if (wr_rise) begin
                        w_cnt   <= 8'(TXE_HOLDOFF);
                        w_state <= W_HOLD;
                    end
                    W_HOLD: begin
                        if (w_cnt <= 8'd1) w_state <= W_IDLE;
                        else               w_cnt   <= w_cnt - 8'd1;
                    end
                    default: w_state <= W_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ftdi_async_dev.sv
// tb/tb_ftdi_async_dev.sv - self-checking bench for ftdi_async_dev
module tb_ftdi_async_dev;
    localparam int DEPTH = 16;
    localparam int RXF_HOLDOFF = 3;
    localparam int TXE_HOLDOFF = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rdn = 1'b1;
    logic       wrn = 1'b1;
    logic [7:0] din = '0;
    logic       rxf, txe, oe;
    logic [7:0] dout;
    logic       hin_valid = 1'b0;
    logic [7:0] hin_data = '0;
    logic       hin_accept;
    logic       hout_valid;
    logic [7:0] hout_data;
    logic       hout_accept = 1'b0;
    logic       err;
`ifdef FTDI_ASYNC_DEV_LOOPBACK_EN
    logic       loopback = 1'b0;
`endif

    int n_tests = 0;
    int n_fail = 0;

    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];
    logic [7:0] got;

    always #5 clk = ~clk;

    ftdi_async_dev #(.DEPTH(DEPTH), .ADDR_W(4), .RXF_HOLDOFF(RXF_HOLDOFF), .TXE_HOLDOFF(TXE_HOLDOFF)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .ftdi_rdn_i       (rdn),
        .ftdi_wrn_i       (wrn),
        .ftdi_data_in_i   (din),
        .ftdi_rxf_o       (rxf),
        .ftdi_txe_o       (txe),
        .ftdi_data_out_o  (dout),
        .ftdi_data_oe_o   (oe),
        .host_in_valid_i  (hin_valid),
        .host_in_data_i   (hin_data),
        .host_in_accept_o (hin_accept),
        .host_out_valid_o (hout_valid),
        .host_out_data_o  (hout_data),
        .host_out_accept_i(hout_accept),
`ifdef FTDI_ASYNC_DEV_LOOPBACK_EN
        .loopback_i       (loopback),
`endif
        .protocol_err_o   (err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        rdn = 1'b1;
        wrn = 1'b1;
        hin_valid = 1'b0;
        hout_accept = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        rx_q.delete();
        tx_q.delete();
    endtask

    task automatic host_push(input logic [7:0] d);
        int t = 0;
        while (!hin_accept && t < 50) begin tick(1); t++; end
        check("push_accept", hin_accept, 1);
        hin_valid = 1'b1;
        hin_data = d;
        tick(1);
        hin_valid = 1'b0;
    endtask

    task automatic host_pop(output logic [7:0] d);
        int t = 0;
        while (!hout_valid && t < 50) begin tick(1); t++; end
        check("pop_valid", hout_valid, 1);
        d = hout_data;
        hout_accept = 1'b1;
        tick(1);
        hout_accept = 1'b0;
    endtask

    task automatic bus_read(output logic [7:0] d);
        int t = 0;
        while (rxf && t < 50) begin tick(1); t++; end
        check("rd_rxf_low", rxf, 0);
        rdn = 1'b0;
        tick(4);
        check("rd_oe", oe, 1);
        d = dout;
        rdn = 1'b1;
        tick(1);
        t = 0;
        while (!rxf && t < 10) begin tick(1); t++; end
        check("rd_rxf_high", rxf, 1);
    endtask

    task automatic bus_write(input logic [7:0] d);
        int t = 0;
        while (txe && t < 50) begin tick(1); t++; end
        check("wr_txe_low", txe, 0);
        din = d;
        wrn = 1'b0;
        tick(4);
        wrn = 1'b1;
        tick(1);
        check("wr_txe_busy", txe, 1);
    endtask

    typedef struct {
        bit         to_host;
        logic [7:0] data;
        logic [7:0] exp_data;
        logic       exp_flag;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;
        vecs[0] = '{0, 8'hA5, 8'hA5, 1'b0};
        vecs[1] = '{1, 8'h3C, 8'h3C, 1'b1};
        vecs[2] = '{0, 8'h00, 8'h00, 1'b0};
        vecs[3] = '{1, 8'hFF, 8'hFF, 1'b1};
        vecs[4] = '{0, 8'h5A, 8'h5A, 1'b0};
        vecs[5] = '{1, 8'h81, 8'h81, 1'b1};

        // reset state
        tick(2);
        check("rst_rxf", rxf, 1);
        check("rst_txe", txe, 1);
        check("rst_hov", hout_valid, 0);
        check("rst_err", err, 0);
        check("rst_oe", oe, 0);
        check("rst_dout", dout, 0);
        rst_n = 1'b1;
        tick(3);
        check("idle_txe", txe, 0);

        for (int i = 0; i < 6; i++) begin
            if (!vecs[i].to_host) begin
                host_push(vecs[i].data);
                tick(8);
                check("vec_rxf", rxf, vecs[i].exp_flag);
                check("vec_dout", dout, vecs[i].exp_data);
                bus_read(got);
                check("vec_rd", got, vecs[i].exp_data);
                tick(8);
                check("vec_rx_empty", rxf, 1);
            end else begin
                bus_write(vecs[i].data);
                tick(2);
                check("vec_hov", hout_valid, vecs[i].exp_flag);
                check("vec_hout", hout_data, vecs[i].exp_data);
                host_pop(got);
                check("vec_pop", got, vecs[i].exp_data);
                tick(10);
                check("vec_txe_back", txe, 0);
            end
        end
        check("vec_err", err, 0);

        // randomized traffic against queue model
        for (int i = 0; i < 80; i++) begin
            int op;
            logic [7:0] b;
            op = $urandom_range(0, 3);
            b = 8'($urandom);
            case (op)
                0: if (rx_q.size() < DEPTH) begin host_push(b); rx_q.push_back(b); end
                1: if (rx_q.size() > 0) begin bus_read(got); check("rnd_rd", got, rx_q.pop_front()); end
                2: if (tx_q.size() < DEPTH) begin bus_write(b); tx_q.push_back(b); end
                default: if (tx_q.size() > 0) begin host_pop(got); check("rnd_pop", got, tx_q.pop_front()); end
            endcase
            tick(1);
            check("rnd_accept", hin_accept, rx_q.size() < DEPTH);
            check("rnd_hov", hout_valid, tx_q.size() != 0);
        end
        check("rnd_err", err, 0);

        // RXF# holdoff after a read, with a second byte waiting
        do_reset();
        host_push(8'h11);
        host_push(8'h22);
        tick(4);
        rdn = 1'b0;
        tick(4);
        check("hold_dout", dout, 8'h11);
        rdn = 1'b1;
        hi = 0;
        while (!rxf && hi < 10) begin tick(1); hi++; end
        hi = 0;
        while (rxf && hi < 50) begin tick(1); hi++; end
        check("rxf_hold_min", hi >= RXF_HOLDOFF, 1);
        check("rxf_hold_max", hi <= RXF_HOLDOFF + 3, 1);
        bus_read(got);
        check("hold_second", got, 8'h22);
        tick(10);
        check("hold_empty_rxf", rxf, 1);

        // TXE# holdoff after a write
        din = 8'h5C;
        wrn = 1'b0;
        tick(4);
        wrn = 1'b1;
        hi = 0;
        while (txe && hi < 50) begin tick(1); hi++; end
        check("txe_hold_min", hi >= TXE_HOLDOFF + 2, 1);
        check("txe_hold_max", hi <= TXE_HOLDOFF + 5, 1);
        host_pop(got);
        check("txe_hold_data", got, 8'h5C);

        // TX FIFO full, overflow write dropped
        do_reset();
        for (int i = 0; i < DEPTH; i++) bus_write(8'(i * 7 + 1));
        tick(12);
        check("full_txe", txe, 1);
        check("full_err0", err, 0);
        din = 8'hEE;
        wrn = 1'b0;
        tick(4);
        wrn = 1'b1;
        tick(8);
        check("full_err", err, 1);
        host_pop(got);
        check("full_first", got, 8'h01);
        tick(10);
        check("full_txe_free", txe, 0);
        for (int i = 1; i < DEPTH; i++) begin
            host_pop(got);
            check("full_drain", got, 8'(i * 7 + 1));
        end
        tick(1);
        check("full_dropped", hout_valid, 0);

        // RD# fall with nothing to read
        do_reset();
        check("rderr_clear", err, 0);
        rdn = 1'b0;
        tick(4);
        check("rderr_oe", oe, 0);
        rdn = 1'b1;
        tick(4);
        check("rderr_err", err, 1);
        check("rderr_rxf", rxf, 1);

        // RD# and WR# low together
        do_reset();
        host_push(8'h77);
        tick(6);
        check("both_rxf0", rxf, 0);
        rdn = 1'b0;
        wrn = 1'b0;
        tick(4);
        check("both_oe", oe, 0);
        check("both_rxf", rxf, 1);
        check("both_err", err, 1);
        rdn = 1'b1;
        wrn = 1'b1;
        tick(10);
        check("both_hov", hout_valid, 0);
        check("both_rxf_back", rxf, 0);
        bus_read(got);
        check("both_byte_kept", got, 8'h77);

        // reset in the middle of a read
        do_reset();
        host_push(8'h42);
        tick(6);
        rdn = 1'b0;
        tick(4);
        check("mid_oe", oe, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rxf", rxf, 1);
        check("mid_txe", txe, 1);
        check("mid_oe_rst", oe, 0);
        check("mid_dout", dout, 0);
        check("mid_hov", hout_valid, 0);
        check("mid_err", err, 0);
        rdn = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(8);
        check("mid_discard", rxf, 1);
        check("mid_accept", hin_accept, 1);

`ifdef FTDI_ASYNC_DEV_LOOPBACK_EN
        do_reset();
        loopback = 1'b1;
        tick(1);
        check("lb_accept", hin_accept, 0);
        bus_write(8'h11);
        bus_write(8'h22);
        tick(10);
        check("lb_hov", hout_valid, 0);
        check("lb_rxf", rxf, 0);
        bus_read(got);
        check("lb_first", got, 8'h11);
        bus_read(got);
        check("lb_second", got, 8'h22);
        loopback = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
